// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_pkg
// Purpose : Shared widths, access-type encodings, arbiter state and owner
//           types for the memory bus arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_bus_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int MEMRW_W = 2;

  // MEM-stage access type as carried by the EX/MEM pipeline register
  localparam logic [MEMRW_W-1:0] MEMRW_IDLE  = 2'b00;
  localparam logic [MEMRW_W-1:0] MEMRW_READ  = 2'b01;
  localparam logic [MEMRW_W-1:0] MEMRW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUS  = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Purpose : Shares a single-port external memory bus between instruction
//           fetch (IF) and the MEM-stage data port. MEM has fixed priority.
//           Each access runs IDLE -> BUS (wait for bus_ack or timeout) ->
//           DONE (one-cycle completion pulse) -> IDLE.
// Ports   : clk, rst                   - clock, synchronous active-high reset
//           if_req/if_addr             - fetch request (level) and address
//           if_done/if_rdata           - fetch completion pulse and data
//           mem_memrw/memaddr/wdata    - MEM-stage access from EX/MEM register
//           mem_done/mem_rdata         - data access completion pulse and data
//           bus_err                    - completion was a timeout abort
//           stallreq_if/stallreq_mem   - combinational stall requests
//           bus_addr/wdata/re/we       - registered external bus drive
//           bus_rdata/bus_ack          - external bus response
// Revision: 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic [MEMRW_W-1:0]  mem_memrw,
  input  logic [ADDR_W-1:0]   mem_memaddr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_done,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err,
  output logic                stallreq_if,
  output logic                stallreq_mem,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic                bus_re,
  output logic                bus_we,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  owner_t           r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic w_mem_active;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_ack;
  logic w_timeout;

  assign w_mem_active = (mem_memrw != MEMRW_IDLE);

  // Next-state and per-cycle control decisions
  always_comb begin
    w_state_nxt = r_state;
    w_grant_mem = 1'b0;
    w_grant_if  = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_mem_active) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ARB_BUS;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ARB_BUS;
        end
      end
      ARB_BUS: begin
        // An ack on the timeout cycle wins over the timeout
        if (bus_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ARB_DONE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ARB_DONE;
        end
      end
      ARB_DONE: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Bus drive, ownership, wait counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= OWNER_IF;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_re    <= 1'b0;
      bus_we    <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (w_grant_mem) begin
      r_owner   <= OWNER_MEM;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      bus_addr  <= mem_memaddr;
      bus_wdata <= mem_wdata;
      bus_re    <= (mem_memrw == MEMRW_READ);
      bus_we    <= (mem_memrw == MEMRW_WRITE);
    end else if (w_grant_if) begin
      r_owner   <= OWNER_IF;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      bus_addr  <= if_addr;
      bus_re    <= 1'b1;
      bus_we    <= 1'b0;
    end else if (w_ack) begin
      bus_re <= 1'b0;
      bus_we <= 1'b0;
      // Only reads update the owner's data; a write ack leaves it alone
      if (bus_re) begin
        if (r_owner == OWNER_MEM) mem_rdata <= bus_rdata;
        else                      if_rdata  <= bus_rdata;
      end
    end else if (w_timeout) begin
      bus_re <= 1'b0;
      bus_we <= 1'b0;
      r_err  <= 1'b1;
      if (r_owner == OWNER_MEM) mem_rdata <= '0;
      else                      if_rdata  <= '0;
    end else if (r_state == ARB_BUS) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign if_done  = (r_state == ARB_DONE) && (r_owner == OWNER_IF);
  assign mem_done = (r_state == ARB_DONE) && (r_owner == OWNER_MEM);
  assign bus_err  = (r_state == ARB_DONE) && r_err;

  assign stallreq_mem = w_mem_active && !mem_done;
  assign stallreq_if  = if_req && !if_done;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port external memory bus between the instruction-fetch port (IF) and the data-access port of the MEM stage.
- The MEM request is sourced from the EX/MEM pipeline register outputs: memrw, memaddr, wdata.
- Sequences each access through an arbitration FSM with a wait-state/ack handshake and a timeout.
- Raises stall requests toward the pipeline controller until each pending access completes.

Parameters:
- TIMEOUT_CYCLES, 16: cycles to wait for bus_ack in BUS state before aborting; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1)
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch address
- if_done  out  1  one-cycle pulse: fetch complete
- if_rdata  out  32  fetch data, valid with if_done
- mem_memrw  in  2  MEM-stage access type: `MemRW_Idle`, `MemRW_Read`, `MemRW_Write`
- mem_memaddr  in  32  data address
- mem_wdata  in  32  store data
- mem_done  out  1  one-cycle pulse: data access complete
- mem_rdata  out  32  load data, valid with mem_done
- bus_err  out  1  one-cycle pulse with done when the access timed out
- stallreq_if  out  1  IF access pending and not completing this cycle
- stallreq_mem  out  1  MEM access pending and not completing this cycle
- bus_addr  out  32  registered bus address
- bus_wdata  out  32  registered bus write data
- bus_re  out  1  registered read strobe
- bus_we  out  1  registered write strobe
- bus_rdata  in  32  bus read data, sampled when bus_ack=1
- bus_ack  in  1  bus completion, one cycle

Behaviour:
- Reset: state=IDLE, counter=0, owner=IF.
  - All outputs 0: bus_re, bus_we, bus_addr, bus_wdata, if_done, mem_done, if_rdata, mem_rdata, bus_err.
  - Reset in any state aborts the access; strobes drop at that same edge.
- The MEM request is active when mem_memrw != `MemRW_Idle`. The value `MemRW_Idle` = 2'b00 never strobes the bus.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If the MEM request is active: owner=MEM, go to BUS. Load bus_addr and bus_wdata; set bus_re=1 for Read or bus_we=1 for Write.
  - Else if if_req=1: owner=IF, go to BUS with bus_re=1.
  - MEM has fixed priority over IF, because the older instruction must finish first.
  - With no request, stay in IDLE.
- BUS:
  - Strobes, address and data are held constant.
  - When bus_ack=1: latch bus_rdata into the owner's rdata register (reads only; write leaves rdata unchanged). Drop the strobes and go to DONE.
  - When counter==TIMEOUT_CYCLES-1 with no ack: drop the strobes, set the error flag, drive rdata to 0 and go to DONE.
  - Otherwise the counter increments. The counter clears on entry to BUS.
  - An ack arriving in the same cycle as the timeout is treated as an ack, with no error.
- DONE (exactly one cycle):
  - The owner's done signal is 1 and bus_err equals the error flag.
  - No new grant is made in this cycle. This gives the requester one edge to retire or change its request.
  - Next state is IDLE.
- Latency: request seen in cycle 0, strobe in cycle 1, ack in cycle 1 at the earliest, done in cycle 2. Minimum access is 3 cycles IDLE→IDLE.
- Stall outputs are combinational:
  - stallreq_mem = memrw active AND NOT (state==DONE AND owner==MEM).
  - stallreq_if = if_req AND NOT (state==DONE AND owner==IF).
- A bus_ack received outside BUS is ignored.
- A request withdrawn while in BUS does not abort the access: it completes normally and done still pulses.

Decomposition:
- Shared defines.v gains:
  - `MemRW_Read` = 2'b01 and `MemRW_Write` = 2'b10, alongside the existing `MemRW_Idle` = 2'b00.
  - Arbiter state encodings `ArbIdle`, `ArbBus`, `ArbDone`.
  - `OwnerIF` and `OwnerMEM`.
- Existing `DataBus`, `DataAddrBus` and `MemRWBus` are reused for widths.
- Single module; the timeout counter is inline and needs no sub-module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, bus_ack after 2 wait cycles with rdata=0x24020005 → bus_re=1 for 3 cycles; if_done pulses one cycle later with if_rdata=0x24020005; stallreq_if=0 in that cycle.
- Simultaneous requests: if_req=1 and memrw=Write (addr 0x2000, wdata 0xDEADBEEF) in the same cycle → MEM is granted first (bus_we=1, bus_wdata=0xDEADBEEF); IF is granted only after the mem_done cycle; stallreq_if stays high throughout.
- Timeout: memrw=Read, bus_ack never asserted, TIMEOUT_CYCLES=4 → strobe for 4 cycles, then mem_done=1, bus_err=1, mem_rdata=0.
- Ack on the timeout cycle: ack in the 4th BUS cycle with rdata=0x55 → mem_done with bus_err=0 and mem_rdata=0x55.
- Reset mid-access: rst=1 during BUS → the next edge gives bus_re=bus_we=0, state IDLE, no done pulse; the request is re-issued after rst drops.
- Spurious ack and idle: bus_ack=1 while in IDLE with no requests → no strobe, no done pulse, all outputs remain 0.
